// File: rtl/cskip_pkg.sv
// -----------------------------------------------------------------------------
// cskip_pkg
// Shared definitions for the pipelined carry-skip adder/subtractor.
//   DEFAULT_WIDTH / DEFAULT_BLOCK : default operand width and skip-group size
//   nblk()                        : number of skip groups for a width/group size
//   stage_cv_t                    : per-stage valid flag plus the carry leaving
//                                   the last group computed in that stage
// -----------------------------------------------------------------------------
package cskip_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_BLOCK = 4;

    function automatic int nblk(input int width, input int block);
        return (block > 0) ? width / block : 0;
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_cv_t;

endpackage

// File: rtl/cskip_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// cskip_adder_pipe_if
// Operand/result handshake bundle of the pipelined carry-skip adder.
//   in_valid/in_ready   : operand transfer (a, b, cin, sub)
//   out_valid/out_ready : result transfer (sum, cout[, ovf])
//   master modport : producer/consumer side (testbench, upstream datapath)
//   slave modport  : adder side
// Optional macro CSKIP_OVF_EN adds the signed-overflow result bit ovf.
// -----------------------------------------------------------------------------
interface cskip_adder_pipe_if
    import cskip_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CSKIP_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef CSKIP_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef CSKIP_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/cskip_group.sv
// -----------------------------------------------------------------------------
// cskip_group
// One carry-skip group of BLOCK bits: ripple sum over propagate/generate with a
// bypass mux that forwards the group carry-in when every bit propagates.
//   p, g : per-bit propagate / generate
//   ci   : group carry-in
//   s    : group sum bits
//   co   : group carry-out
// -----------------------------------------------------------------------------
module cskip_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] p,
    input  logic [BLOCK-1:0] g,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co
);

    logic rip_c;

    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        rip_c = c;
    end

    // Bypass: when the whole group propagates, the carry-out is the carry-in,
    // so the long path through the ripple is not on the critical chain.
    assign co = (&p) ? ci : rip_c;

endmodule

// File: rtl/cskip_adder_pipe.sv
// -----------------------------------------------------------------------------
// cskip_adder_pipe
// Parametrised pipelined carry-skip adder/subtractor with valid/ready handshake
// and whole-pipeline stall.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cskip_adder_pipe_if.slave (in_valid/in_ready/a/b/cin/sub,
//          out_valid/out_ready/sum/cout[/ovf])
// Parameters: WIDTH (multiple of BLOCK), BLOCK (skip group size),
//             STAGES (1..NBLK, must divide NBLK = WIDTH/BLOCK).
// Optional macro CSKIP_OVF_EN: adds the registered signed-overflow output ovf.
//
// Stage s computes groups s*GPS .. s*GPS+GPS-1. Operand propagate/generate bits
// not yet consumed travel down a shrinking skew register; finished sum bits
// accumulate in a growing de-skew register so the whole sum leaves together.
// -----------------------------------------------------------------------------
module cskip_adder_pipe
    import cskip_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int BLOCK  = DEFAULT_BLOCK,
    parameter int STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    cskip_adder_pipe_if.slave bus
);

    localparam int NBLK  = nblk(WIDTH, BLOCK);
    localparam int GPS   = (STAGES > 0) ? NBLK / STAGES : NBLK;
    localparam int SBITS = GPS * BLOCK;

    generate
        if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_width
            $error("cskip_adder_pipe: WIDTH=%0d must be a positive multiple of BLOCK=%0d", WIDTH, BLOCK);
        end
        if (STAGES < 1 || STAGES > NBLK || (NBLK % STAGES) != 0) begin : g_bad_stages
            $error("cskip_adder_pipe: STAGES=%0d must be 1..%0d and divide %0d groups", STAGES, NBLK, NBLK);
        end
    endgenerate

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] grp_sum;
    logic             c_in;

    // Every stage moves together; bubbles advance too, so a full pipeline
    // only waits on the output register.
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    assign b_eff = bus.b ^ {WIDTH{bus.sub}};
    assign p_in  = bus.a ^ b_eff;
    assign g_in  = bus.a & b_eff;
    assign c_in  = bus.sub ? 1'b1 : bus.cin;

    genvar gi;

    // ---------------------------------------------------------------- groups
    for (gi = 0; gi < NBLK; gi++) begin : g_grp
        localparam int ST  = gi / GPS;
        // Bit offset of this group inside the skew register feeding stage ST.
        localparam int OFF = gi * BLOCK - ST * SBITS;

        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] s;
        logic             ci;
        logic             co;

        if (ST == 0) begin : g_src_in
            assign p = p_in[gi*BLOCK +: BLOCK];
            assign g = g_in[gi*BLOCK +: BLOCK];
        end else begin : g_src_skew
            assign p = g_stg[ST-1].g_skew.p_reg[OFF +: BLOCK];
            assign g = g_stg[ST-1].g_skew.g_reg[OFF +: BLOCK];
        end

        if ((gi % GPS) == 0) begin : g_head
            if (ST == 0) begin : g_c_in
                assign ci = c_in;
            end else begin : g_c_reg
                assign ci = g_stg[ST-1].cv_reg.carry;
            end
        end else begin : g_tail
            assign ci = g_grp[gi-1].co;
        end

        cskip_group #(.BLOCK(BLOCK)) u_group (
            .p  (p),
            .g  (g),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        assign grp_sum[gi*BLOCK +: BLOCK] = s;
    end

    // ---------------------------------------------------------------- stages
    for (gi = 0; gi < STAGES; gi++) begin : g_stg
        localparam int DONE = (gi + 1) * SBITS;    // sum bits finished here
        localparam int LAST = gi * GPS + GPS - 1;  // last group of this stage

        logic            v_in;
        logic [DONE-1:0] sum_next;
        logic [DONE-1:0] sum_reg;
        stage_cv_t       cv_next;
        stage_cv_t       cv_reg;

        if (gi == 0) begin : g_first
            assign v_in     = bus.in_valid;
            assign sum_next = grp_sum[DONE-1:0];
        end else begin : g_later
            assign v_in     = g_stg[gi-1].cv_reg.valid;
            assign sum_next = {grp_sum[DONE-1 -: SBITS], g_stg[gi-1].sum_reg};
        end

        assign cv_next = '{valid: v_in, carry: g_grp[LAST].co};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cv_reg  <= '0;
                sum_reg <= '0;
            end else if (en) begin
                cv_reg  <= cv_next;
                sum_reg <= sum_next;
            end
        end

        // Operand bits still waiting for later stages.
        if (gi < STAGES - 1) begin : g_skew
            localparam int REM = WIDTH - DONE;

            logic [REM-1:0] p_next;
            logic [REM-1:0] g_next;
            logic [REM-1:0] p_reg;
            logic [REM-1:0] g_reg;

            if (gi == 0) begin : g_from_in
                assign p_next = p_in[WIDTH-1:DONE];
                assign g_next = g_in[WIDTH-1:DONE];
            end else begin : g_from_skew
                assign p_next = g_stg[gi-1].g_skew.p_reg[REM+SBITS-1:SBITS];
                assign g_next = g_stg[gi-1].g_skew.g_reg[REM+SBITS-1:SBITS];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_reg <= '0;
                    g_reg <= '0;
                end else if (en) begin
                    p_reg <= p_next;
                    g_reg <= g_next;
                end
            end
        end
    end

`ifdef CSKIP_OVF_EN
    logic ovf_next;
    logic ovf_reg;

    // Carry into the MSB is recovered as s^p of that bit; xor with the carry
    // out of the MSB gives two's-complement overflow.
    assign ovf_next = g_grp[NBLK-1].s[BLOCK-1] ^ g_grp[NBLK-1].p[BLOCK-1]
                    ^ g_grp[NBLK-1].co;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (en) begin
            ovf_reg <= ovf_next;
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.out_valid = g_stg[STAGES-1].cv_reg.valid;
    assign bus.cout      = g_stg[STAGES-1].cv_reg.carry;
    assign bus.sum       = g_stg[STAGES-1].sum_reg;

endmodule
